axis_frame_gen: RTL and testbench
=================================

# axis_frame_gen

Synthesizable, runtime-configurable AXI4-Stream frame generator for driving the DMA S2MM path in simulation and on hardware. It emits `num_frames` frames of `frame_len` beats, separated by a programmable idle gap, while honouring `tready` backpressure. It supports a partial final-beat `tkeep`, continuous mode and graceful stop. It sits between a control source (AXI-Lite register block or bench task) and the DMA `S_AXIS_S2MM` port.

## Interface
- `DATA_WIDTH`, 32, tdata width; multiple of 8, at least 32.
- `CNTR_WIDTH`, 4, width of the beat-index field in the low bits of tdata.
- `FIXED_DATA`, 28'h666A500, constant upper field; width DATA_WIDTH-CNTR_WIDTH.
- `LEN_WIDTH`, 16, width of `frame_len`.
- `NUM_WIDTH`, 16, width of `num_frames` and `frames_sent`.
- `GAP_WIDTH`, 16, width of `frame_gap`.
- `aclk  in  1`  clock; all logic on rising edge.
- `arstn  in  1`  reset, asynchronous assert, active-low.
- `start  in  1`  one-cycle request; acted on only in IDLE.
- `stop  in  1`  one-cycle request; finish the current frame, then halt.
- `frame_len  in  LEN_WIDTH`  beats per frame; 0 is treated as 1.
- `num_frames  in  NUM_WIDTH`  frames per run; 0 means continuous until stop.
- `frame_gap  in  GAP_WIDTH`  idle cycles between frames.
- `last_keep  in  DATA_WIDTH/8`  tkeep on the tlast beat; 0 is treated as all ones.
- `busy  out  1`  high from the cycle after start is accepted until the cycle done pulses.
- `done  out  1`  one-cycle pulse at end of run.
- `frames_sent  out  NUM_WIDTH`  completed frames in the current run; cleared on start; wraps.
- `M_AXIS_tdata  out  DATA_WIDTH`
- `M_AXIS_tkeep  out  DATA_WIDTH/8`
- `M_AXIS_tlast  out  1`
- `M_AXIS_tvalid  out  1`
- `M_AXIS_tready  in  1`

## Operation
- States:
  - IDLE: start moves to SEND, latches frame_len/num_frames/frame_gap/last_keep, clears frames_sent.
  - SEND: on a tlast handshake, go to IDLE if the run is complete or stop is pending; else go to GAP if the latched gap is >0; else stay in SEND.
  - GAP: count down the latched gap, then go to SEND.
- Config inputs are sampled only at start; changes mid-run are ignored.
- Beat index resets to 0 at each frame start and increments per handshake, modulo 2^CNTR_WIDTH.
  - Counter data: tdata = {FIXED_DATA, beat_index}.
- tkeep is all ones on every beat except the tlast beat, which carries the latched last_keep.
- tlast is asserted on beat frame_len-1.
- Run complete: frames_sent reaches the latched num_frames (num_frames ≠ 0).
- stop in IDLE is ignored. stop during SEND or GAP sets a pending flag:
  - SEND: the current frame completes normally.
  - GAP: go straight to IDLE with done.
- start while busy is ignored. start and stop in the same IDLE cycle: start is taken, stop is dropped.
- frames_sent increments on each tlast handshake.

## Timing
- Reset values: tvalid, tlast, busy, done = 0; tdata, tkeep, frames_sent = 0; state IDLE.
- Reset asserted mid-frame clears all outputs immediately (asynchronous); the partial frame is abandoned.
- start accepted at edge N: tvalid and busy are high from N+1.
- AXIS rules:
  - Once tvalid is high, tvalid, tdata, tkeep and tlast are held until tready.
  - tvalid never depends combinationally on tready.
- With tready held high, one beat per cycle. A frame of L beats occupies L cycles.
- gap=0: the first beat of the next frame follows the tlast handshake with no bubble.
- gap=G: exactly G cycles with tvalid low between the tlast handshake and the next first beat.
- done pulses and busy falls in the cycle after the final tlast handshake; tvalid is low that cycle.

## Configuration
- `AXIS_FRAME_GEN_PRBS_EN` defined:
  - Adds input `data_mode` (1 bit, latched at start). 1 selects PRBS data.
  - PRBS source: 31-bit LFSR, x^31+x^28+1, seeded 31'h7FFFFFFF at each frame start, advanced one step per handshake.
  - PRBS tdata: LFSR state zero-extended to DATA_WIDTH.
  - tkeep and tlast behaviour are unchanged.
- Not defined: no `data_mode` port, no LFSR logic; counter data only.

## Test plan
- frame_len=16, num_frames=1, gap=0, tready=1, start -> 16 beats:
  - tdata 32'h666A5000..32'h666A500F; tlast on beat 15.
  - done one cycle after the last beat; frames_sent=1.
- frame_len=4, num_frames=3, gap=5, tready=1 -> three frames with exactly 5 tvalid-low cycles between them; frames_sent=3.
- frame_len=8, tready toggling 1/0 every cycle -> tdata/tlast stable while stalled; 8 handshakes with beat indices 0..7.
- num_frames=0, frame_len=10, stop asserted at beat 3 of frame 2 -> frame 2 completes through beat 9; done next cycle; frames_sent=2.
- last_keep=4'b0011, frame_len=2 -> tkeep 4'hF on beat 0, 4'h3 on beat 1 with tlast.
- arstn pulled low at beat 5 of 16, then released, then start -> outputs 0 during reset; the new run restarts at beat index 0.

Source files
------------

// File: rtl/axis_frame_gen.sv
// AXI4-Stream frame generator: counted frames with idle gaps, partial last-beat tkeep and graceful stop.
// Optional PRBS data source: define AXIS_FRAME_GEN_PRBS_EN to add the data_mode input and LFSR.
module axis_frame_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int CNTR_WIDTH = 4,
  parameter logic [DATA_WIDTH-CNTR_WIDTH-1:0] FIXED_DATA = 28'h666A500,
  parameter int LEN_WIDTH  = 16,
  parameter int NUM_WIDTH  = 16,
  parameter int GAP_WIDTH  = 16
) (
  input  logic                    aclk,
  input  logic                    arstn,
  input  logic                    start,
  input  logic                    stop,
  input  logic [LEN_WIDTH-1:0]    frame_len,
  input  logic [NUM_WIDTH-1:0]    num_frames,
  input  logic [GAP_WIDTH-1:0]    frame_gap,
  input  logic [DATA_WIDTH/8-1:0] last_keep,
`ifdef AXIS_FRAME_GEN_PRBS_EN
  input  logic                    data_mode,
`endif
  output logic                    busy,
  output logic                    done,
  output logic [NUM_WIDTH-1:0]    frames_sent,
  output logic [DATA_WIDTH-1:0]   M_AXIS_tdata,
  output logic [DATA_WIDTH/8-1:0] M_AXIS_tkeep,
  output logic                    M_AXIS_tlast,
  output logic                    M_AXIS_tvalid,
  input  logic                    M_AXIS_tready
);

  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [LEN_WIDTH-1:0]    r_len;
  logic [NUM_WIDTH-1:0]    r_num;
  logic [GAP_WIDTH-1:0]    r_gap;
  logic [KEEP_WIDTH-1:0]   r_keep;
  logic [GAP_WIDTH-1:0]    r_gap_cnt;
  logic [LEN_WIDTH-1:0]    r_beat;
  logic [CNTR_WIDTH-1:0]   r_idx;
  logic [NUM_WIDTH-1:0]    r_frames;
  logic                    r_stop_pend;
  logic                    r_done;
`ifdef AXIS_FRAME_GEN_PRBS_EN
  logic                    r_mode;
  logic [30:0]             r_lfsr;
  localparam logic [30:0]  LFSR_SEED = 31'h7FFFFFFF;
`endif

  logic                    w_valid;
  logic                    w_last;
  logic                    w_hs;
  logic                    w_last_hs;
  logic [NUM_WIDTH-1:0]    w_frames_inc;
  logic                    w_run_done;
  logic                    w_stop_now;

  assign w_valid      = (r_state == ST_SEND);
  assign w_last       = (r_beat == (r_len - LEN_WIDTH'(1)));
  assign w_hs         = w_valid & M_AXIS_tready;
  assign w_last_hs    = w_hs & w_last;
  assign w_frames_inc = r_frames + NUM_WIDTH'(1);
  assign w_run_done   = (r_num != '0) && (w_frames_inc == r_num);
  // A stop arriving in the same cycle as the tlast handshake or a gap cycle acts immediately.
  assign w_stop_now   = r_stop_pend | stop;

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next = ST_SEND;
        end
      end
      ST_SEND: begin
        if (w_last_hs) begin
          if (w_run_done || w_stop_now) begin
            w_next = ST_IDLE;
          end else if (r_gap != '0) begin
            w_next = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (w_stop_now) begin
          w_next = ST_IDLE;
        end else if (r_gap_cnt == GAP_WIDTH'(1)) begin
          w_next = ST_SEND;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      r_len       <= LEN_WIDTH'(1);
      r_num       <= '0;
      r_gap       <= '0;
      r_keep      <= '1;
      r_gap_cnt   <= '0;
      r_beat      <= '0;
      r_idx       <= '0;
      r_frames    <= '0;
      r_stop_pend <= 1'b0;
      r_done      <= 1'b0;
`ifdef AXIS_FRAME_GEN_PRBS_EN
      r_mode      <= 1'b0;
      r_lfsr      <= LFSR_SEED;
`endif
    end else begin
      r_done <= (r_state != ST_IDLE) && (w_next == ST_IDLE);
      if (r_state == ST_IDLE) begin
        if (start) begin
          r_len       <= (frame_len == '0) ? LEN_WIDTH'(1) : frame_len;
          r_num       <= num_frames;
          r_gap       <= frame_gap;
          r_keep      <= (last_keep == '0) ? '1 : last_keep;
          r_beat      <= '0;
          r_idx       <= '0;
          r_frames    <= '0;
          r_stop_pend <= 1'b0;
`ifdef AXIS_FRAME_GEN_PRBS_EN
          r_mode      <= data_mode;
          r_lfsr      <= LFSR_SEED;
`endif
        end
      end else begin
        if (stop) begin
          r_stop_pend <= 1'b1;
        end
        if (w_hs) begin
          if (w_last) begin
            r_beat   <= '0;
            r_idx    <= '0;
            r_frames <= w_frames_inc;
`ifdef AXIS_FRAME_GEN_PRBS_EN
            r_lfsr   <= LFSR_SEED;
`endif
          end else begin
            r_beat <= r_beat + LEN_WIDTH'(1);
            r_idx  <= r_idx + CNTR_WIDTH'(1);
`ifdef AXIS_FRAME_GEN_PRBS_EN
            r_lfsr <= {r_lfsr[29:0], r_lfsr[30] ^ r_lfsr[27]};
`endif
          end
        end
        // The gap counter is preloaded while sending so it is ready on entry to GAP.
        if (r_state == ST_SEND) begin
          r_gap_cnt <= r_gap;
        end else begin
          r_gap_cnt <= r_gap_cnt - GAP_WIDTH'(1);
        end
      end
    end
  end

  always_comb begin
    M_AXIS_tvalid = w_valid;
    M_AXIS_tlast  = w_valid & w_last;
    M_AXIS_tkeep  = '0;
    M_AXIS_tdata  = '0;
    if (w_valid) begin
      M_AXIS_tkeep = w_last ? r_keep : '1;
      M_AXIS_tdata = {FIXED_DATA, r_idx};
`ifdef AXIS_FRAME_GEN_PRBS_EN
      if (r_mode) begin
        M_AXIS_tdata = DATA_WIDTH'(r_lfsr);
      end
`endif
    end
    busy        = (r_state != ST_IDLE);
    done        = r_done;
    frames_sent = r_frames;
  end

endmodule

// File: tb/tb_axis_frame_gen.sv
// Scoreboard bench for axis_frame_gen: a frame-level reference model fills expectation queues,
// and a negedge monitor pops and compares every handshake, gap length and end-of-run pulse.
module tb_axis_frame_gen;

  logic        aclk = 1'b0;
  logic        arstn = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] frame_len = '0;
  logic [15:0] num_frames = '0;
  logic [15:0] frame_gap = '0;
  logic [3:0]  last_keep = '0;
  logic        busy;
  logic        done;
  logic [15:0] frames_sent;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast;
  logic        tvalid;
  logic        tready = 1'b0;
`ifdef AXIS_FRAME_GEN_PRBS_EN
  logic        data_mode = 1'b0;
`endif

  axis_frame_gen dut (
    .aclk          (aclk),
    .arstn         (arstn),
    .start         (start),
    .stop          (stop),
    .frame_len     (frame_len),
    .num_frames    (num_frames),
    .frame_gap     (frame_gap),
    .last_keep     (last_keep),
`ifdef AXIS_FRAME_GEN_PRBS_EN
    .data_mode     (data_mode),
`endif
    .busy          (busy),
    .done          (done),
    .frames_sent   (frames_sent),
    .M_AXIS_tdata  (tdata),
    .M_AXIS_tkeep  (tkeep),
    .M_AXIS_tlast  (tlast),
    .M_AXIS_tvalid (tvalid),
    .M_AXIS_tready (tready)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  beat_t expBeats[$];
  int    expGaps[$];
  int    vectors = 0;
  int    miscompares = 0;
  bit    monEn = 1'b0;
  bit    doneSeen = 1'b0;
  bit    inGap = 1'b0;
  bit    prevStall = 1'b0;
  bit    checkDoneTiming = 1'b1;
  int    runHs = 0;
  int    mcyc = 0;
  int    lastHsCyc = -10;
  int    gapCnt = 0;
  int    expFramesSent = 0;
  beat_t prevBeat;
  beat_t monExp;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: samples mid-cycle, so the values seen are the ones the next rising edge will take.
  always @(negedge aclk) begin
    mcyc++;
    if (monEn) begin
      if (prevStall) begin
        checkOutput("stall_hold", 64'({tvalid, tdata, tkeep, tlast}), 64'({1'b1, prevBeat}));
      end
      prevStall = tvalid && !tready;
      prevBeat  = '{data: tdata, keep: tkeep, last: tlast};
      if (tvalid && inGap) begin
        inGap = 1'b0;
        if (expGaps.size() == 0) begin
          checkOutput("unexpected_frame", 64'd1, 64'd0);
        end else begin
          checkOutput("gap_cycles", 64'(gapCnt), 64'(expGaps.pop_front()));
        end
      end else if (!tvalid && inGap && !done) begin
        gapCnt++;
      end
      if (tvalid && tready) begin
        if (expBeats.size() == 0) begin
          checkOutput("extra_beat", 64'd1, 64'd0);
        end else begin
          monExp = expBeats.pop_front();
          checkOutput("beat", 64'({tdata, tkeep, tlast}), 64'(monExp));
        end
        runHs++;
        if (tlast) begin
          inGap     = 1'b1;
          gapCnt    = 0;
          lastHsCyc = mcyc;
        end
      end
      if (done) begin
        doneSeen = 1'b1;
        inGap    = 1'b0;
        if (checkDoneTiming) begin
          checkOutput("done_timing", 64'(mcyc - lastHsCyc), 64'd1);
        end
        checkOutput("done_valid_busy", 64'({tvalid, busy}), 64'd0);
        checkOutput("frames_sent", 64'(frames_sent), 64'(expFramesSent));
      end
    end
  end

  // One run: sw selects no stop (0), stop at beat sb of frame sf (1), or stop in the gap after frame sf (2).
  task automatic applyStimulus(input int len, input int num, input int gap, input int keep,
                               input int rmode, input int sw, input int sf, input int sb);
    int    effLen;
    int    effKeep;
    int    nFrames;
    int    cyc;
    int    target;
    bit    stopIssued;
    beat_t nb;
    effLen  = (len == 0) ? 1 : len;
    effKeep = (keep == 0) ? 15 : keep;
    nFrames = (sw == 0) ? num : sf + 1;
    expBeats.delete();
    expGaps.delete();
    for (int f = 0; f < nFrames; f++) begin
      for (int b = 0; b < effLen; b++) begin
        nb.data = 32'h666A5000 + 32'(b % 16);
        nb.keep = (b == effLen - 1) ? 4'(effKeep) : 4'hF;
        nb.last = (b == effLen - 1);
        expBeats.push_back(nb);
      end
      if (f < nFrames - 1) expGaps.push_back(gap);
    end
    expFramesSent   = nFrames;
    checkDoneTiming = (sw != 2);
    runHs      = 0;
    inGap      = 1'b0;
    doneSeen   = 1'b0;
    prevStall  = 1'b0;
    stopIssued = 1'b0;
    target     = (sw == 1) ? sf * effLen + sb : (sf + 1) * effLen;

    @(posedge aclk); #1;
    frame_len  = 16'(len);
    num_frames = 16'(num);
    frame_gap  = 16'(gap);
    last_keep  = 4'(keep);
    start      = 1'b1;
    stop       = 1'b1;
    tready     = 1'b0;
    monEn      = 1'b1;
    @(posedge aclk); #1;
    frame_len  = 16'($urandom);
    num_frames = 16'($urandom);
    frame_gap  = 16'($urandom);
    last_keep  = 4'($urandom);
    cyc = 0;
    while (!doneSeen && cyc < 3000) begin
      tready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
      stop   = 1'b0;
      start  = (cyc == 2 && nFrames * effLen >= 4);
      if (!stopIssued && sw == 1 && tvalid && runHs == target) begin
        stop = 1'b1;
        stopIssued = 1'b1;
      end
      if (!stopIssued && sw == 2 && !tvalid && busy && runHs == target) begin
        stop = 1'b1;
        stopIssued = 1'b1;
      end
      @(negedge aclk);
      if (cyc == 0) checkOutput("busy_after_start", 64'({busy, tvalid}), 64'd3);
      @(posedge aclk); #1;
      cyc++;
    end
    start = 1'b0;
    stop  = 1'b0;
    if (!doneSeen) checkOutput("run_timeout", 64'd0, 64'd1);
    checkOutput("beats_left", 64'(expBeats.size()), 64'd0);
    checkOutput("gaps_left", 64'(expGaps.size()), 64'd0);
    @(negedge aclk);
    checkOutput("done_pulse", 64'(done), 64'd0);
    monEn = 1'b0;
    @(posedge aclk); #1;
    stop = 1'b1;
    @(posedge aclk); #1;
    stop = 1'b0;
  endtask

  initial begin
    int len, num, gap, keep, rmode, sw, sf, sb, effLen;
    #2;
    checkOutput("reset_outputs", 64'({tvalid, tlast, busy, done, tdata, tkeep, frames_sent}), 64'd0);
    repeat (2) @(negedge aclk);
    arstn = 1'b1;

    applyStimulus(16, 1, 0, 15, 0, 0, 0, 0);
    applyStimulus(4, 3, 5, 15, 0, 0, 0, 0);
    applyStimulus(8, 1, 0, 15, 1, 0, 0, 0);
    applyStimulus(10, 0, 2, 15, 0, 1, 1, 3);
    applyStimulus(2, 1, 0, 3, 0, 0, 0, 0);
    applyStimulus(0, 2, 1, 0, 2, 0, 0, 0);
    applyStimulus(6, 0, 3, 5, 2, 2, 1, 0);

    // Reset pulled in the middle of a frame, then a fresh run must restart at beat 0.
    @(posedge aclk); #1;
    frame_len = 16; num_frames = 1; frame_gap = 0; last_keep = 0;
    start = 1'b1; tready = 1'b1;
    @(posedge aclk); #1;
    start = 1'b0;
    repeat (5) @(posedge aclk);
    #2;
    checkOutput("pre_reset_beat", 64'({tvalid, tdata}), 64'({1'b1, 32'h666A5005}));
    arstn = 1'b0;
    #1;
    checkOutput("midframe_reset", 64'({tvalid, tlast, busy, done, tdata, tkeep, frames_sent}), 64'd0);
    @(negedge aclk);
    arstn = 1'b1;
    applyStimulus(16, 1, 0, 0, 0, 0, 0, 0);

    for (int r = 0; r < 20; r++) begin
      len   = $urandom_range(0, 12);
      num   = $urandom_range(0, 4);
      gap   = $urandom_range(0, 4);
      keep  = $urandom_range(0, 15);
      rmode = $urandom_range(0, 2);
      sw    = $urandom_range(0, 2);
      if (num == 0 && len < 2) len = 5;
      effLen = (len == 0) ? 1 : len;
      if (sw == 2 && (gap == 0 || (num != 0 && num < 2))) sw = 1;
      if (sw == 1 && effLen < 2) sw = 0;
      if (num == 0 && sw == 0) sw = 1;
      if (sw == 0) sf = 0;
      else if (num == 0) sf = $urandom_range(0, 2);
      else if (sw == 1) sf = $urandom_range(0, num - 1);
      else sf = $urandom_range(0, num - 2);
      sb = (sw == 1) ? $urandom_range(0, effLen - 2) : 0;
      applyStimulus(len, num, gap, keep, rmode, sw, sf, sb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
